ip_rule_filter: RTL and testbench
=================================

Name: ip_rule_filter

Overview:
- Parametrised successor to the single-address Rx IP filter.
- Watches the GMAC receive byte stream and extracts the 4-byte IPv4 address at a configurable frame offset.
- Compares that address against NUM_RULES runtime-programmable address/mask rules and reports a per-packet verdict with the index of the winning rule.
- Sits beside the Rx MAC core on rxcoreclk; drop/forward logic downstream consumes the verdict.

Parameters:
- NUM_RULES, 4, number of address/mask rule entries (1..16).
- IP_OFFSET, 26, byte index of the first address byte. Byte 0 is the first dvld-high byte of the frame; 26 selects source IP, 30 selects destination IP.
- IDX_W, $clog2(NUM_RULES) (minimum 1), rule-index width (derived; not overridden).

Ports:
- rxcoreclk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- gmac_rx_data, input, 8, Rx byte, valid when gmac_rx_dvld=1.
- gmac_rx_dvld, input, 1, frame data valid; a low cycle ends the frame.
- cfg_we, input, 1, rule write strobe.
- cfg_idx, input, IDX_W, rule entry written.
- cfg_addr, input, 32, rule address, MSB = first byte on wire.
- cfg_mask, input, 32, 1 = bit compared.
- cfg_en, input, 1, rule enable written with the entry.
- verdict_vld, output, 1, one-cycle pulse per frame.
- match, output, 1, frame matched an enabled rule; held until next frame start.
- match_idx, output, IDX_W, lowest-index matching rule; held with match.
- runt, output, 1, frame ended before the address was complete; held until next frame start.

Behaviour:
- Reset (already decided): reset, synchronous, active-high; clock rxcoreclk.
- Reset values: all outputs 0; byte counter 0; every rule entry cleared (addr=0, mask=0, en=0); state WAIT_END.
- Reset asserted mid-frame: the frame is abandoned and no verdict is issued for it.
- States:
  - IDLE: clears match, runt, match_idx. On dvld=1, the byte is index 0; go to HDR.
  - HDR: counter increments on each dvld byte. When the byte at IP_OFFSET is sampled, go to CAPTURE.
  - CAPTURE: shift bytes into a 32-bit ip_q. After the byte at IP_OFFSET+3, go to EVAL.
  - EVAL: one cycle. Computes hit[i] = en[i] & (((ip_q ^ addr[i]) & mask[i]) == 0). Registers match = |hit, match_idx = lowest set index (0 if none), and pulses verdict_vld. Go to WAIT_END.
  - WAIT_END: go to IDLE on dvld=0.
- Latency: verdict_vld is high in the cycle after the EVAL cycle, i.e. 2 cycles after the edge that samples byte IP_OFFSET+3.
- Early frame end: dvld=0 in HDR or CAPTURE (dvld already high for ≥1 byte) → runt=1, verdict_vld pulse, match=0, then IDLE.
- Frame ending exactly after byte IP_OFFSET+3: evaluated normally; WAIT_END exits on that low cycle.
- Back-to-back frames require ≥1 dvld-low cycle between them; that cycle is consumed by WAIT_END/IDLE.
- Counter width is $clog2(IP_OFFSET+4). The counter stops at IP_OFFSET+3 and never wraps.
- Config writes land at the next edge. A write in the EVAL cycle is not seen by that evaluation, which uses the old entry.
- Writes are accepted in every state and are not affected by frame activity.
- A rule with mask=0 and en=1 matches every complete frame.

Optional Feature:
- Macro: IP_RULE_FILTER_STATS_EN.
- Defined: adds a per-rule 32-bit saturating hit counter, incremented on verdict_vld for match_idx when match=1.
  - Adds ports stat_idx (input, IDX_W) and stat_cnt (output, 32), registered read, 1-cycle latency.
  - Counters are cleared by reset and by a cfg_we to the same entry.
- Undefined: no counters and no stat ports; functional behaviour is identical.

Decomposition:
- Package ip_filter_pkg:
  - state enum (IDLE, HDR, CAPTURE, EVAL, WAIT_END);
  - rule struct {addr, mask, en};
  - function rule_hit(ip, rule);
  - offset constants SRC_IP_OFFSET=26, DST_IP_OFFSET=30.
- Sub-module ip_rule_table: rule storage, config write port, combinational hit vector, priority encoder, optional stats counters.
- Top level: byte FSM, counter, capture register, output registers.

Test Plan:
- Rule0 = C0A80178/FFFFFFFF enabled; 64-byte frame with bytes 26..29 = C0 A8 01 78 → verdict_vld 2 cycles after byte 29; match=1, match_idx=0, runt=0.
- Rule1 = C0A80100/FFFFFF00, rule2 = C0A80105/FFFFFFFF; frame carrying C0A80105 → match=1, match_idx=1 (priority); disable rule1 → next frame gives match_idx=2.
- No rules enabled; frame carrying C0A80178 → verdict_vld=1, match=0; then enable rule with mask 00000000 → next frame match=1.
- Frame with dvld dropping after byte 27 → verdict_vld pulse, runt=1, match=0; following full frame clears runt at its start.
- Reset asserted at byte 28 of a matching frame → no verdict; outputs 0; dvld still high → no verdict until dvld low then a new frame; rule table empty afterwards.
- cfg_we changing rule0 address in the EVAL cycle → that frame uses the old value; the next identical frame uses the new value. With STATS_EN: stat_cnt[0] increments by exactly 1 per matching frame.

Source files
------------

// File: rtl/ip_filter_pkg.sv
// Shared types and helpers for the IPv4 address/mask rule filter.
package ip_filter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CAPTURE,
    EVAL,
    WAIT_END
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] mask;
    logic        en;
  } rule_t;

  localparam int SRC_IP_OFFSET = 26;
  localparam int DST_IP_OFFSET = 30;

  function automatic logic rule_hit(input logic [31:0] ip, input rule_t rule);
    return rule.en & (((ip ^ rule.addr) & rule.mask) == 32'h0);
  endfunction

endpackage

// File: rtl/ip_rule_table.sv
// Rule storage with config write port, combinational hit vector and lowest-index priority encoder.
// Optional per-rule saturating hit counters when IP_RULE_FILTER_STATS_EN is defined.
module ip_rule_table
  import ip_filter_pkg::*;
#(
  parameter int NUM_RULES = 4,
  parameter int IDX_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic             rxcoreclk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [31:0]      cfg_addr,
  input  logic [31:0]      cfg_mask,
  input  logic             cfg_en,
  input  logic [31:0]      ip,
`ifdef IP_RULE_FILTER_STATS_EN
  input  logic             stat_inc,
  input  logic [IDX_W-1:0] stat_inc_idx,
  input  logic [IDX_W-1:0] stat_idx,
  output logic [31:0]      stat_cnt,
`endif
  output logic             hit_any,
  output logic [IDX_W-1:0] hit_idx
);

  rule_t                rules [NUM_RULES];
  logic [NUM_RULES-1:0] hit;
  logic                 cfg_ok;

  assign cfg_ok = (int'(cfg_idx) < NUM_RULES);

  always_ff @(posedge rxcoreclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_RULES; i++) rules[i] <= '0;
    end else if (cfg_we && cfg_ok) begin
      rules[cfg_idx] <= {cfg_addr, cfg_mask, cfg_en};
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_RULES; i++) hit[i] = rule_hit(ip, rules[i]);
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = IDX_W'(i);
    end
    hit_any = |hit;
  end

`ifdef IP_RULE_FILTER_STATS_EN
  logic [31:0] cnt [NUM_RULES];

  // Reprogramming an entry restarts its count; that takes precedence over a hit.
  always_ff @(posedge rxcoreclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_RULES; i++) cnt[i] <= '0;
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_RULES; i++) begin
        if (cfg_we && cfg_idx == IDX_W'(i)) begin
          cnt[i] <= '0;
        end else if (stat_inc && stat_inc_idx == IDX_W'(i) && cnt[i] != 32'hFFFF_FFFF) begin
          cnt[i] <= cnt[i] + 32'd1;
        end
      end
      stat_cnt <= (int'(stat_idx) < NUM_RULES) ? cnt[stat_idx] : 32'h0;
    end
  end
`endif

endmodule

// File: rtl/ip_rule_filter.sv
// Rx byte-stream IPv4 address filter: captures the address at IP_OFFSET and reports a per-frame verdict.
// Define IP_RULE_FILTER_STATS_EN to add per-rule hit counters and the stat_idx/stat_cnt read port.
module ip_rule_filter
  import ip_filter_pkg::*;
#(
  parameter int NUM_RULES = 4,
  parameter int IP_OFFSET = SRC_IP_OFFSET,
  parameter int IDX_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic             rxcoreclk,
  input  logic             reset,
  input  logic [7:0]       gmac_rx_data,
  input  logic             gmac_rx_dvld,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [31:0]      cfg_addr,
  input  logic [31:0]      cfg_mask,
  input  logic             cfg_en,
`ifdef IP_RULE_FILTER_STATS_EN
  input  logic [IDX_W-1:0] stat_idx,
  output logic [31:0]      stat_cnt,
`endif
  output logic             verdict_vld,
  output logic             match,
  output logic [IDX_W-1:0] match_idx,
  output logic             runt
);

  localparam int CNT_W = $clog2(IP_OFFSET + 4);
  localparam logic [CNT_W-1:0] OFS_FIRST = CNT_W'(IP_OFFSET);
  localparam logic [CNT_W-1:0] OFS_LAST  = CNT_W'(IP_OFFSET + 3);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      ip_q;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;

  logic clr_out, cnt_ld, cnt_inc, cap, runt_set, eval_now;

  always_ff @(posedge rxcoreclk) begin
    if (reset) state <= WAIT_END;
    else       state <= state_nx;
  end

  // EVAL leaves straight for IDLE when its cycle is already the inter-frame gap.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (gmac_rx_dvld) state_nx = (IP_OFFSET == 0) ? CAPTURE : HDR;
      HDR:      if (!gmac_rx_dvld) state_nx = IDLE;
                else if (cnt == OFS_FIRST) state_nx = CAPTURE;
      CAPTURE:  if (!gmac_rx_dvld) state_nx = IDLE;
                else if (cnt == OFS_LAST) state_nx = EVAL;
      EVAL:     state_nx = gmac_rx_dvld ? WAIT_END : IDLE;
      WAIT_END: if (!gmac_rx_dvld) state_nx = IDLE;
      default:  state_nx = WAIT_END;
    endcase
  end

  // cnt holds the index of the byte currently on the bus while in HDR/CAPTURE.
  always_comb begin
    clr_out  = 1'b0;
    cnt_ld   = 1'b0;
    cnt_inc  = 1'b0;
    cap      = 1'b0;
    runt_set = 1'b0;
    eval_now = 1'b0;
    case (state)
      IDLE: if (gmac_rx_dvld) begin
        clr_out = 1'b1;
        cnt_ld  = 1'b1;
        cap     = (IP_OFFSET == 0);
      end
      HDR: if (gmac_rx_dvld) begin
        cnt_inc = 1'b1;
        cap     = (cnt == OFS_FIRST);
      end else begin
        runt_set = 1'b1;
      end
      CAPTURE: if (gmac_rx_dvld) begin
        cap     = 1'b1;
        cnt_inc = (cnt != OFS_LAST);
      end else begin
        runt_set = 1'b1;
      end
      EVAL:    eval_now = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge rxcoreclk) begin
    if (reset) begin
      cnt         <= '0;
      ip_q        <= '0;
      verdict_vld <= 1'b0;
      match       <= 1'b0;
      match_idx   <= '0;
      runt        <= 1'b0;
    end else begin
      verdict_vld <= eval_now | runt_set;
      if (cnt_ld)       cnt <= CNT_W'(1);
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (cap) ip_q <= {ip_q[23:0], gmac_rx_data};
      if (clr_out || runt_set) begin
        match     <= 1'b0;
        match_idx <= '0;
        runt      <= runt_set;
      end else if (eval_now) begin
        match     <= hit_any;
        match_idx <= hit_idx;
        runt      <= 1'b0;
      end
    end
  end

  ip_rule_table #(
    .NUM_RULES(NUM_RULES),
    .IDX_W    (IDX_W)
  ) u_table (
    .rxcoreclk   (rxcoreclk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_addr    (cfg_addr),
    .cfg_mask    (cfg_mask),
    .cfg_en      (cfg_en),
    .ip          (ip_q),
`ifdef IP_RULE_FILTER_STATS_EN
    .stat_inc    (verdict_vld & match),
    .stat_inc_idx(match_idx),
    .stat_idx    (stat_idx),
    .stat_cnt    (stat_cnt),
`endif
    .hit_any     (hit_any),
    .hit_idx     (hit_idx)
  );

endmodule

// File: tb/tb_ip_rule_filter.sv
// Directed table-driven bench for ip_rule_filter (NUM_RULES=4, IP_OFFSET=26).
module tb_ip_rule_filter;

  localparam int NR  = 4;
  localparam int OFS = 26;
  localparam int IW  = 2;

  logic          rxcoreclk = 1'b0;
  logic          reset;
  logic [7:0]    gmac_rx_data;
  logic          gmac_rx_dvld;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [31:0]   cfg_addr, cfg_mask;
  logic          cfg_en;
  logic          verdict_vld, match, runt;
  logic [IW-1:0] match_idx;
`ifdef IP_RULE_FILTER_STATS_EN
  logic [IW-1:0] stat_idx;
  logic [31:0]   stat_cnt;
`endif

  always #5 rxcoreclk = ~rxcoreclk;

  ip_rule_filter #(.NUM_RULES(NR), .IP_OFFSET(OFS)) dut (
    .rxcoreclk   (rxcoreclk),
    .reset       (reset),
    .gmac_rx_data(gmac_rx_data),
    .gmac_rx_dvld(gmac_rx_dvld),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_addr    (cfg_addr),
    .cfg_mask    (cfg_mask),
    .cfg_en      (cfg_en),
`ifdef IP_RULE_FILTER_STATS_EN
    .stat_idx    (stat_idx),
    .stat_cnt    (stat_cnt),
`endif
    .verdict_vld (verdict_vld),
    .match       (match),
    .match_idx   (match_idx),
    .runt        (runt)
  );

  int cyc = 0;
  always @(posedge rxcoreclk) cyc <= cyc + 1;

  int            v_cnt = 0;
  int            v_cyc = 0;
  logic          v_match = 1'b0, v_runt = 1'b0;
  logic [IW-1:0] v_idx = '0;
  always @(negedge rxcoreclk) begin
    if (verdict_vld) begin
      v_cnt   <= v_cnt + 1;
      v_cyc   <= cyc;
      v_match <= match;
      v_idx   <= match_idx;
      v_runt  <= runt;
    end
  end

  int            errors = 0, checks = 0;
  int            b29_cyc = 0, low_cyc = 0;
  logic          start_match, start_runt;
  logic [IW-1:0] pend_idx;
  logic [31:0]   pend_addr, pend_mask;
  logic          pend_en;

  typedef struct {
    bit            do_cfg;
    logic [IW-1:0] idx;
    logic [31:0]   addr;
    logic [31:0]   mask;
    bit            en;
    int            len;
    logic [31:0]   ip;
    bit            e_match;
    int            e_idx;
    bit            e_runt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [IW-1:0] idx, input logic [31:0] addr,
                           input logic [31:0] mask, input logic en);
    @(posedge rxcoreclk); #1;
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = addr; cfg_mask = mask; cfg_en = en;
    @(posedge rxcoreclk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [31:0] ip, input int rst_at, input int cfg_at);
    logic [31:0] t;
    for (int b = 0; b < len; b++) begin
      @(posedge rxcoreclk); #1;
      if (b == 1) begin
        start_match = match;
        start_runt  = runt;
      end
      gmac_rx_dvld = 1'b1;
      reset        = 1'b0;
      cfg_we       = 1'b0;
      if (b >= OFS && b <= OFS + 3) begin
        t = ip >> (8 * (OFS + 3 - b));
        gmac_rx_data = t[7:0];
      end else begin
        gmac_rx_data = 8'(b) ^ 8'h5A;
      end
      if (b == OFS + 3) b29_cyc = cyc;
      if (b == cfg_at) begin
        cfg_we = 1'b1; cfg_idx = pend_idx; cfg_addr = pend_addr;
        cfg_mask = pend_mask; cfg_en = pend_en;
      end
      if (b == rst_at) reset = 1'b1;
    end
    @(posedge rxcoreclk); #1;
    gmac_rx_dvld = 1'b0; gmac_rx_data = 8'h00; cfg_we = 1'b0; reset = 1'b0;
    low_cyc = cyc;
    repeat (4) @(posedge rxcoreclk);
    #1;
  endtask

  task automatic frame_check(input string name, input int len, input logic [31:0] ip,
                             input bit e_match, input int e_idx, input bit e_runt, input int cfg_at);
    int v0;
    int exp_cyc;
    v0 = v_cnt;
    send_frame(len, ip, -1, cfg_at);
    exp_cyc = (len >= OFS + 4) ? b29_cyc + 2 : low_cyc + 1;
    chk($sformatf("%s verdicts", name), v_cnt - v0, 1);
    chk($sformatf("%s match", name), {31'b0, v_match}, {31'b0, e_match});
    chk($sformatf("%s match_idx", name), {30'b0, v_idx}, e_idx);
    chk($sformatf("%s runt", name), {31'b0, v_runt}, {31'b0, e_runt});
    chk($sformatf("%s latency", name), v_cyc, exp_cyc);
    chk($sformatf("%s match held", name), {31'b0, match}, {31'b0, e_match});
    if (len > 1) begin
      chk($sformatf("%s match cleared at start", name), {31'b0, start_match}, 0);
      chk($sformatf("%s runt cleared at start", name), {31'b0, start_runt}, 0);
    end
  endtask

  initial begin
`ifdef IP_RULE_FILTER_STATS_EN
    logic [31:0] s0;
    stat_idx = '0;
`endif
    int v0;
    reset = 1'b1; gmac_rx_dvld = 1'b0; gmac_rx_data = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_mask = '0; cfg_en = 1'b0;
    pend_idx = '0; pend_addr = '0; pend_mask = '0; pend_en = 1'b0;

    vecs[0]  = '{1, 0, 32'hC0A80178, 32'hFFFFFFFF, 1, 64, 32'hC0A80178, 1, 0, 0};
    vecs[1]  = '{1, 2, 32'hC0A80105, 32'hFFFFFFFF, 1, 64, 32'hC0A80105, 1, 2, 0};
    vecs[2]  = '{1, 1, 32'hC0A80100, 32'hFFFFFF00, 1, 64, 32'hC0A80105, 1, 1, 0};
    vecs[3]  = '{1, 1, 32'hC0A80100, 32'hFFFFFF00, 0, 64, 32'hC0A80105, 1, 2, 0};
    vecs[4]  = '{0, 0, 32'h0, 32'h0, 0, 64, 32'h0A000001, 0, 0, 0};
    vecs[5]  = '{0, 0, 32'h0, 32'h0, 0, 28, 32'hC0A80178, 0, 0, 1};
    vecs[6]  = '{0, 0, 32'h0, 32'h0, 0, 64, 32'hC0A80178, 1, 0, 0};
    vecs[7]  = '{0, 0, 32'h0, 32'h0, 0, 30, 32'hC0A80105, 1, 2, 0};
    vecs[8]  = '{0, 0, 32'h0, 32'h0, 0, 26, 32'hC0A80178, 0, 0, 1};
    vecs[9]  = '{0, 0, 32'h0, 32'h0, 0, 29, 32'hC0A80178, 0, 0, 1};
    vecs[10] = '{1, 3, 32'hC0A80000, 32'hFFFF0000, 1, 64, 32'hC0A8FFFF, 1, 3, 0};
    vecs[11] = '{0, 0, 32'h0, 32'h0, 0, 1, 32'hC0A80178, 0, 0, 1};
    vecs[12] = '{0, 0, 32'h0, 32'h0, 0, 64, 32'hC0A80178, 1, 0, 0};

    repeat (3) @(posedge rxcoreclk);
    #1;
    chk("reset verdict_vld", {31'b0, verdict_vld}, 0);
    chk("reset match", {31'b0, match}, 0);
    chk("reset match_idx", {30'b0, match_idx}, 0);
    chk("reset runt", {31'b0, runt}, 0);
    reset = 1'b0;
    repeat (3) @(posedge rxcoreclk);
    #1;
    chk("no verdict after reset", v_cnt, 0);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_cfg) cfg_write(vecs[i].idx, vecs[i].addr, vecs[i].mask, vecs[i].en);
      frame_check($sformatf("vec%0d", i), vecs[i].len, vecs[i].ip,
                  vecs[i].e_match, vecs[i].e_idx, vecs[i].e_runt, -1);
    end

    // rule0 rewritten during the EVAL cycle (byte OFS+4 on the bus): old entry still decides
    pend_idx = 0; pend_addr = 32'h0A000001; pend_mask = 32'hFFFFFFFF; pend_en = 1'b1;
    frame_check("eval_write", 64, 32'hC0A80178, 1, 0, 0, OFS + 4);
    frame_check("after_write", 64, 32'hC0A80178, 1, 3, 0, -1);
`ifdef IP_RULE_FILTER_STATS_EN
    stat_idx = 0;
    repeat (2) @(posedge rxcoreclk);
    #1;
    s0 = stat_cnt;
`endif
    frame_check("new_addr", 64, 32'h0A000001, 1, 0, 0, -1);
`ifdef IP_RULE_FILTER_STATS_EN
    repeat (2) @(posedge rxcoreclk);
    #1;
    chk("stat_cnt rule0 delta", stat_cnt - s0, 1);
`endif

    // reset while byte 28 of a matching frame is on the bus
    v0 = v_cnt;
    send_frame(64, 32'hC0A80178, OFS + 2, -1);
    chk("mid reset verdicts", v_cnt - v0, 0);
    chk("mid reset match", {31'b0, match}, 0);
    chk("mid reset runt", {31'b0, runt}, 0);
    chk("mid reset verdict_vld", {31'b0, verdict_vld}, 0);
    frame_check("empty_table", 64, 32'hC0A80178, 0, 0, 0, -1);
    cfg_write(3, 32'h12345678, 32'h00000000, 1'b1);
    frame_check("mask0", 64, 32'h01020304, 1, 3, 0, -1);
    frame_check("mask0_runt", 20, 32'h01020304, 0, 0, 1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
